mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl_if.sv | 53 +++++
 rtl/mem_port_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if
// Bundles the fetch port, the data port and the dual-port memory side of
// mem_port_ctrl. The clock (clcka) and reset (rstn) are not part of the bundle.
//
//   slave  : the controller view (mem_port_ctrl)
//   master : the environment view (fetch/data clients plus the memory)
//
// Signal summary
//   f_req/f_addr           fetch read request, held until f_ack
//   f_ack/f_valid/f_data   fetch accept pulse, read valid pulse, read data
//   d_req/d_we/d_addr/d_wdata  data request (write when d_we=1)
//   d_ack/d_valid/d_rdata  data accept pulse, read valid pulse, read data
//   a1/w1/w1_ena/r1_ena/r1 memory port 1 (fetch, read-only)
//   a2/w2/w2_ena/r2_ena/r2 memory port 2 (data)
//   r1/r2 are valid the cycle after the enable edge.
interface mem_port_ctrl_if;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_ack;
   logic        f_valid;
   logic [15:0] f_data;

   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic        d_valid;
   logic [15:0] d_rdata;

   logic [15:0] a1;
   logic [15:0] a2;
   logic [15:0] w1;
   logic [15:0] w2;
   logic        w1_ena;
   logic        w2_ena;
   logic        r1_ena;
   logic        r2_ena;
   logic [15:0] r1;
   logic [15:0] r2;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, r1, r2,
      output f_ack, f_valid, f_data, d_ack, d_valid, d_rdata,
      output a1, a2, w1, w2, w1_ena, w2_ena, r1_ena, r2_ena
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, r1, r2,
      input  f_ack, f_valid, f_data, d_ack, d_valid, d_rdata,
      input  a1, a2, w1, w2, w1_ena, w2_ena, r1_ena, r2_ena
   );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
// Two-client controller for a dual-port memory. The fetch client is read-only
// and owns memory port 1; the data client reads and writes through port 2.
// Each port runs an ISSUE / MEM / CAPTURE pipeline:
//   edge N   : request sampled, ack + memory command registered
//   edge N+1 : memory samples the command
//   edge N+2 : read data captured, valid pulsed
// so valid follows ack by two cycles, and a held request is accepted every
// cycle.
//
// Ports
//   clcka  rising-edge clock
//   rstn   asynchronous active-low reset; clears every output and stage
//   io     mem_port_ctrl_if.slave (fetch, data and memory-side signals)
//
// Configuration macro: MEM_HAZARD_BYPASS_EN
//   A collision is a fetch and a data write to the same address sampled on
//   the same edge.
//   undefined : the fetch ack is withheld one cycle and the fetch reads the
//               memory after the write has landed.
//   defined   : the fetch is acked with the write and returns the write data
//               forwarded through the fetch pipeline; port 1 is not enabled.
//
// Fetch issue FSM
//   state  | meaning
//   F_RUN  | normal issue; a colliding fetch is withheld (no bypass)
//   F_HOLD | fetch was withheld last cycle; issue it now unconditionally
module mem_port_ctrl (
   input  logic           clcka,
   input  logic           rstn,
   mem_port_ctrl_if.slave io
);

   typedef enum logic {
      F_RUN  = 1'b0,
      F_HOLD = 1'b1
   } f_state_t;

   f_state_t    r_f_state;

   // fetch pipeline
   logic        r_f_ack;
   logic        r_f_s2;
   logic        r_f_valid;
   logic [15:0] r_f_data;
   logic [15:0] r_a1;
   logic        r_r1_ena;

   // data pipeline
   logic        r_d_ack;
   logic        r_d_s2;
   logic        r_d_valid;
   logic [15:0] r_d_rdata;
   logic [15:0] r_a2;
   logic [15:0] r_w2;
   logic        r_w2_ena;
   logic        r_r2_ena;

   logic        w_collide;
   logic        w_f_issue;
   logic        w_f_rd;

`ifdef MEM_HAZARD_BYPASS_EN
   // forwarded write data rides alongside the fetch through MEM and CAPTURE
   logic        r_f_s1_fwd;
   logic [15:0] r_f_s1_fdata;
   logic        r_f_s2_fwd;
   logic [15:0] r_f_s2_fdata;
`endif

   // A fetch released from F_HOLD is never treated as a collision again,
   // which bounds the stall to one cycle.
   assign w_collide = io.f_req & io.d_req & io.d_we &
                      (io.f_addr == io.d_addr) & (r_f_state == F_RUN);

`ifdef MEM_HAZARD_BYPASS_EN
   assign w_f_issue = io.f_req;
   assign w_f_rd    = io.f_req & ~w_collide;
`else
   assign w_f_issue = io.f_req & ~w_collide;
   assign w_f_rd    = w_f_issue;
`endif

   always_ff @(posedge clcka or negedge rstn) begin
      if (!rstn) begin
         r_f_state <= F_RUN;
         r_f_ack   <= 1'b0;
         r_f_s2    <= 1'b0;
         r_f_valid <= 1'b0;
         r_f_data  <= '0;
         r_a1      <= '0;
         r_r1_ena  <= 1'b0;
`ifdef MEM_HAZARD_BYPASS_EN
         r_f_s1_fwd   <= 1'b0;
         r_f_s1_fdata <= '0;
         r_f_s2_fwd   <= 1'b0;
         r_f_s2_fdata <= '0;
`endif
      end else begin
         case (r_f_state)
            F_RUN: begin
`ifndef MEM_HAZARD_BYPASS_EN
               if (w_collide) r_f_state <= F_HOLD;
`endif
            end
            F_HOLD:  r_f_state <= F_RUN;
            default: r_f_state <= F_RUN;
         endcase

         // ISSUE
         r_f_ack  <= w_f_issue;
         r_r1_ena <= w_f_rd;
         if (w_f_issue) r_a1 <= io.f_addr;
`ifdef MEM_HAZARD_BYPASS_EN
         r_f_s1_fwd <= w_collide;
         if (w_collide) r_f_s1_fdata <= io.d_wdata;
         r_f_s2_fwd <= r_f_s1_fwd;
         if (r_f_s1_fwd) r_f_s2_fdata <= r_f_s1_fdata;
`endif

         // MEM
         r_f_s2 <= r_f_ack;

         // CAPTURE
         r_f_valid <= r_f_s2;
         if (r_f_s2) begin
`ifdef MEM_HAZARD_BYPASS_EN
            r_f_data <= r_f_s2_fwd ? r_f_s2_fdata : io.r1;
`else
            r_f_data <= io.r1;
`endif
         end
      end
   end

   always_ff @(posedge clcka or negedge rstn) begin
      if (!rstn) begin
         r_d_ack   <= 1'b0;
         r_d_s2    <= 1'b0;
         r_d_valid <= 1'b0;
         r_d_rdata <= '0;
         r_a2      <= '0;
         r_w2      <= '0;
         r_w2_ena  <= 1'b0;
         r_r2_ena  <= 1'b0;
      end else begin
         // ISSUE
         r_d_ack  <= io.d_req;
         r_w2_ena <= io.d_req & io.d_we;
         r_r2_ena <= io.d_req & ~io.d_we;
         if (io.d_req) r_a2 <= io.d_addr;
         if (io.d_req && io.d_we) r_w2 <= io.d_wdata;

         // MEM: only reads travel on, writes never produce d_valid
         r_d_s2 <= r_r2_ena;

         // CAPTURE
         r_d_valid <= r_d_s2;
         if (r_d_s2) r_d_rdata <= io.r2;
      end
   end

   assign io.f_ack   = r_f_ack;
   assign io.f_valid = r_f_valid;
   assign io.f_data  = r_f_data;
   assign io.a1      = r_a1;
   assign io.r1_ena  = r_r1_ena;
   assign io.w1      = '0;
   assign io.w1_ena  = 1'b0;

   assign io.d_ack   = r_d_ack;
   assign io.d_valid = r_d_valid;
   assign io.d_rdata = r_d_rdata;
   assign io.a2      = r_a2;
   assign io.w2      = r_w2;
   assign io.w2_ena  = r_w2_ena;
   assign io.r2_ena  = r_r2_ena;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl
// Bench for mem_port_ctrl: a behavioural dual-port memory, a shadow memory
// of expected contents, per-port scoreboards of expected read data and
// expected valid cycle, a table of single-cycle request vectors and a few
// hand-written multi-cycle sequences (stream, collision, reset mid-read).
// Honours MEM_HAZARD_BYPASS_EN for the collision timing.
module tb_mem_port_ctrl;

   logic clcka;
   logic rstn;

   mem_port_ctrl_if bus();

   mem_port_ctrl dut (
      .clcka (clcka),
      .rstn  (rstn),
      .io    (bus)
   );

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } sb_t;

   typedef struct {
      logic        f_req;
      logic [15:0] f_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic        e_f_ack;
      logic        e_d_ack;
      logic        e_w2_ena;
      logic        e_r1_ena;
      logic        e_r2_ena;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [15:0] mem     [0:65535];
   logic [15:0] exp_mem [0:65535];
   sb_t         fq [$];
   sb_t         dq [$];
   vec_t        vecs [8];

   logic [103:0] all_outs;
   assign all_outs = {bus.f_ack, bus.f_valid, bus.f_data, bus.d_ack, bus.d_valid,
                      bus.d_rdata, bus.a1, bus.a2, bus.w1, bus.w2,
                      bus.w1_ena, bus.w2_ena, bus.r1_ena, bus.r2_ena};

   initial begin
      clcka = 1'b0;
      forever #5 clcka = ~clcka;
   end

   always @(posedge clcka) cyc <= cyc + 1;

   // memory model: synchronous read, data valid after the enable edge
   always @(posedge clcka) begin
      if (bus.w2_ena) mem[bus.a2] <= bus.w2;
      if (bus.r1_ena) bus.r1 <= mem[bus.a1];
      if (bus.r2_ena) bus.r2 <= mem[bus.a2];
   end

   function automatic logic [15:0] init_val(int i);
      logic [15:0] a;
      a = i[15:0];
      if (i < 4) return 16'hA000 + a;
      return 16'hC000 ^ a;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_f(logic [15:0] data, int at);
      sb_t s;
      s.data = data;
      s.cyc  = at;
      fq.push_back(s);
   endfunction

   function automatic void push_d(logic [15:0] data, int at);
      sb_t s;
      s.data = data;
      s.cyc  = at;
      dq.push_back(s);
   endfunction

   // scoreboard side: every valid pulse must match the oldest expectation
   always @(negedge clcka) begin
      sb_t e;
      if (rstn) begin
         if (bus.f_valid) begin
            if (fq.size() == 0) check("f_valid_spurious", {31'b0, bus.f_valid}, 32'd0);
            else begin
               e = fq.pop_front();
               check("f_data", {16'b0, bus.f_data}, {16'b0, e.data});
               check("f_valid_cycle", cyc, e.cyc);
            end
         end
         if (bus.d_valid) begin
            if (dq.size() == 0) check("d_valid_spurious", {31'b0, bus.d_valid}, 32'd0);
            else begin
               e = dq.pop_front();
               check("d_rdata", {16'b0, bus.d_rdata}, {16'b0, e.data});
               check("d_valid_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic clear_inputs();
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
   endtask

   // drive one vector for one edge (called just after a negedge)
   task automatic apply(input vec_t v, input int idx);
      bus.f_req   = v.f_req;
      bus.f_addr  = v.f_addr;
      bus.d_req   = v.d_req;
      bus.d_we    = v.d_we;
      bus.d_addr  = v.d_addr;
      bus.d_wdata = v.d_wdata;
      if (v.d_req && v.d_we) exp_mem[v.d_addr] = v.d_wdata;
      if (v.f_req) push_f(exp_mem[v.f_addr], cyc + 3);
      if (v.d_req && !v.d_we) push_d(exp_mem[v.d_addr], cyc + 3);
      @(negedge clcka);
      check($sformatf("v%0d_f_ack", idx), {31'b0, bus.f_ack}, {31'b0, v.e_f_ack});
      check($sformatf("v%0d_d_ack", idx), {31'b0, bus.d_ack}, {31'b0, v.e_d_ack});
      check($sformatf("v%0d_w2_ena", idx), {31'b0, bus.w2_ena}, {31'b0, v.e_w2_ena});
      check($sformatf("v%0d_r1_ena", idx), {31'b0, bus.r1_ena}, {31'b0, v.e_r1_ena});
      check($sformatf("v%0d_r2_ena", idx), {31'b0, bus.r2_ena}, {31'b0, v.e_r2_ena});
      check($sformatf("v%0d_port1_wr", idx), {15'b0, bus.w1_ena, bus.w1}, 32'd0);
      if (v.f_req) check($sformatf("v%0d_a1", idx), {16'b0, bus.a1}, {16'b0, v.f_addr});
      if (v.d_req) check($sformatf("v%0d_a2", idx), {16'b0, bus.a2}, {16'b0, v.d_addr});
      if (v.d_req && v.d_we) check($sformatf("v%0d_w2", idx), {16'b0, bus.w2}, {16'b0, v.d_wdata});
      clear_inputs();
   endtask

   initial begin
      int m;
      int cnt;
      //          f_req f_addr    d_req d_we d_addr    d_wdata    fack dack w2e r1e r2e
      vecs[0] = '{1'b1, 16'h0004, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0300, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 16'h0300, 1'b1, 1'b0, 16'h0301, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 16'h0009, 1'b1, 1'b1, 16'h0008, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 65536; i++) begin
         mem[i]     = init_val(i);
         exp_mem[i] = init_val(i);
      end
      bus.r1 = '0;
      bus.r2 = '0;
      clear_inputs();

      // reset state
      rstn = 1'b0;
      repeat (2) @(negedge clcka);
      check("reset_outputs_zero", {31'b0, |all_outs}, 32'd0);
      rstn = 1'b1;

      // table of single-edge requests
      for (int i = 0; i < 8; i++) apply(vecs[i], i);
      repeat (4) @(negedge clcka);

      // fetch stream: four back-to-back requests at 0x0000..0x0003
      m = cyc;
      for (int i = 0; i < 4; i++) begin
         bus.f_req  = 1'b1;
         bus.f_addr = i[15:0];
         push_f(exp_mem[i], cyc + 3);
         @(negedge clcka);
         check($sformatf("stream%0d_f_ack", i), {31'b0, bus.f_ack}, 32'd1);
      end
      bus.f_req = 1'b0;
      repeat (3) @(negedge clcka);
      check("stream_done_cycle", cyc, m + 7);
      check("f_data_hold", {15'b0, bus.f_valid, bus.f_data}, {16'b0, exp_mem[3]});
      check("d_rdata_hold", {15'b0, bus.d_valid, bus.d_rdata}, {16'b0, exp_mem[8]});

      // collision: write 0x1234 to 0x0008 while fetching 0x0008
      m = cyc;
      bus.f_req   = 1'b1;
      bus.f_addr  = 16'h0008;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 16'h0008;
      bus.d_wdata = 16'h1234;
      exp_mem[8]  = 16'h1234;
`ifdef MEM_HAZARD_BYPASS_EN
      push_f(exp_mem[8], m + 3);
      @(negedge clcka);
      check("coll_d_ack", {31'b0, bus.d_ack}, 32'd1);
      check("coll_f_ack", {31'b0, bus.f_ack}, 32'd1);
      clear_inputs();
      @(negedge clcka);
      check("coll_f_ack_after", {31'b0, bus.f_ack}, 32'd0);
`else
      push_f(exp_mem[8], m + 4);
      @(negedge clcka);
      check("coll_d_ack", {31'b0, bus.d_ack}, 32'd1);
      check("coll_f_ack_withheld", {31'b0, bus.f_ack}, 32'd0);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      @(negedge clcka);
      check("coll_f_ack_late", {31'b0, bus.f_ack}, 32'd1);
      check("coll_d_ack_late", {31'b0, bus.d_ack}, 32'd0);
      check("coll_r1_ena_late", {31'b0, bus.r1_ena}, 32'd1);
      clear_inputs();
`endif
      repeat (5) @(negedge clcka);

      // reset in the middle of a fetch of 0x0010
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0010;
      @(negedge clcka);
      check("rst_pre_f_ack", {31'b0, bus.f_ack}, 32'd1);
      clear_inputs();
      rstn = 1'b0;
      #1;
      check("rst_mid_outputs_zero", {31'b0, |all_outs}, 32'd0);
      @(negedge clcka);
      check("rst_hold_outputs_zero", {31'b0, |all_outs}, 32'd0);
      @(negedge clcka);
      rstn       = 1'b1;
      bus.f_req  = 1'b1;
      bus.f_addr = 16'h0002;
      push_f(exp_mem[2], cyc + 3);
      @(negedge clcka);
      check("rst_first_f_ack", {31'b0, bus.f_ack}, 32'd1);
      clear_inputs();
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clcka);
         if (bus.f_valid) cnt++;
      end
      check("rst_f_valid_count", cnt, 32'd1);

      repeat (4) @(negedge clcka);
      check("fetch_queue_drained", fq.size(), 32'd0);
      check("data_queue_drained", dq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
